wasm_frame_ctrl: RTL and testbench

Call-frame controller sitting directly upstream of the operand stack in the WASM core. It tracks the active function frame (base pointer and size), keeps a stack of saved caller frames with return PCs, and drives the operand stack's `call`/`retu`/`allocate_local_memory_size`/`control_stack_tag`/`l_addr` inputs. It also translates local indices into absolute stack addresses and reports frame overflow, illegal requests and program completion to the sequencer.

---
 rtl/wasm_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_wasm_frame_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_frame_ctrl.sv
// Call-frame controller: tracks the active frame, saves caller frames with return PCs,
// and drives the operand stack's call/return/allocation/tag/local-address inputs.
module wasm_frame_ctrl #(
    parameter int FRAME_DEPTH = 16,
    parameter int PC_W        = 16,
    parameter int PTR_W       = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           call_vld,
    input  logic [7:0]                     call_param_num,
    input  logic [7:0]                     call_local_num,
    input  logic [PC_W-1:0]                call_ret_pc,
    input  logic                           ret_vld,
    input  logic [PTR_W-1:0]               top_pointer,
    input  logic [7:0]                     local_idx,
    output logic                           call_go,
    output logic                           ret_go,
    output logic [7:0]                     alloc_size,
    output logic [PTR_W-1:0]               frame_base,
    output logic [PTR_W-1:0]               l_addr,
    output logic                           local_oob,
    output logic [PC_W-1:0]                ret_pc,
    output logic                           ret_pc_vld,
    output logic [$clog2(FRAME_DEPTH):0]   depth,
    output logic                           done,
    output logic                           trap,
    output logic [1:0]                     trap_code
);
    localparam int AW = $clog2(FRAME_DEPTH);
    localparam int DW = AW + 1;
    localparam int CW = (PTR_W > 8) ? PTR_W : 8;
    localparam int SW = CW + 1;
    localparam int EW = PC_W + PTR_W + 9;

    typedef enum logic [1:0] {RUN, TRAP, DONE} state_t;

    state_t          state;
    logic [8:0]      frame_size;
    logic [EW-1:0]   frame_mem [FRAME_DEPTH];

    logic [CW-1:0]   top_ext;
    logic [CW-1:0]   param_ext;
    logic [CW-1:0]   new_base_ext;
    logic [SW-1:0]   l_sum;
    logic [DW-1:0]   depth_m1;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic            in_run;
    logic            param_uf;
    logic            frames_full;
    logic            depth_zero;
    logic [8:0]      new_size;
    logic [PC_W-1:0] ent_pc;
    logic [PTR_W-1:0] ent_base;
    logic [8:0]      ent_size;

    assign in_run       = (state == RUN);
    assign top_ext      = CW'(top_pointer);
    assign param_ext    = CW'(call_param_num);
    assign param_uf     = param_ext > top_ext;
    assign new_base_ext = top_ext - param_ext;
    assign frames_full  = (depth == DW'(FRAME_DEPTH));
    assign depth_zero   = (depth == '0);
    assign new_size     = {1'b0, call_param_num} + {1'b0, call_local_num};

    assign depth_m1 = depth - 1'b1;
    assign wr_idx   = depth[AW-1:0];
    assign rd_idx   = depth_m1[AW-1:0];
    assign {ent_pc, ent_base, ent_size} = frame_mem[rd_idx];

    // Simultaneous call+ret is a trap, so neither strobe may fire in that cycle.
    assign call_go = in_run && call_vld && !ret_vld && !param_uf && !frames_full;
    assign ret_go  = in_run && ret_vld && !call_vld && !depth_zero;

    assign alloc_size = call_local_num;
    assign l_sum      = SW'(frame_base) + SW'(local_idx);
    assign l_addr     = l_sum[PTR_W-1:0];
    assign local_oob  = ({1'b0, local_idx} >= frame_size);

    // Saved-frame storage carries no reset; only entries below depth are ever read.
    always_ff @(posedge clk) begin
        if (call_go)
            frame_mem[wr_idx] <= {call_ret_pc, frame_base, frame_size};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            frame_base <= '0;
            frame_size <= '0;
            depth      <= '0;
            ret_pc     <= '0;
            ret_pc_vld <= 1'b0;
            done       <= 1'b0;
            trap       <= 1'b0;
            trap_code  <= 2'b00;
        end else begin
            ret_pc_vld <= ret_go;
            case (state)
                RUN: begin
                    if (call_vld && ret_vld) begin
                        state     <= TRAP;
                        trap      <= 1'b1;
                        trap_code <= 2'b11;
                    end else if (call_vld) begin
                        if (param_uf) begin
                            state     <= TRAP;
                            trap      <= 1'b1;
                            trap_code <= 2'b10;
                        end else if (frames_full) begin
                            state     <= TRAP;
                            trap      <= 1'b1;
                            trap_code <= 2'b01;
                        end else begin
                            frame_base <= new_base_ext[PTR_W-1:0];
                            frame_size <= new_size;
                            depth      <= depth + 1'b1;
                        end
                    end else if (ret_vld) begin
                        if (depth_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            frame_base <= ent_base;
                            frame_size <= ent_size;
                            ret_pc     <= ent_pc;
                            depth      <= depth_m1;
                        end
                    end
                end
                TRAP:    state <= TRAP;
                DONE:    state <= DONE;
                default: state <= TRAP;
            endcase
        end
    end
endmodule

// File: tb/tb_wasm_frame_ctrl.sv
// Directed bench for wasm_frame_ctrl: a vector table for the basic call/return flow,
// plus hand sequences for overflow, conflicting requests, completion and async reset.
module tb_wasm_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        call_vld, ret_vld;
    logic [7:0]  call_param_num, call_local_num, local_idx;
    logic [15:0] call_ret_pc;
    logic [8:0]  top_pointer;
    logic        call_go, ret_go, local_oob, ret_pc_vld, done, trap;
    logic [7:0]  alloc_size;
    logic [8:0]  frame_base, l_addr;
    logic [15:0] ret_pc;
    logic [4:0]  depth;
    logic [1:0]  trap_code;

    int n_checks = 0;
    int n_pass   = 0;

    wasm_frame_ctrl #(.FRAME_DEPTH(16), .PC_W(16), .PTR_W(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .call_vld(call_vld), .call_param_num(call_param_num), .call_local_num(call_local_num),
        .call_ret_pc(call_ret_pc), .ret_vld(ret_vld), .top_pointer(top_pointer),
        .local_idx(local_idx), .call_go(call_go), .ret_go(ret_go), .alloc_size(alloc_size),
        .frame_base(frame_base), .l_addr(l_addr), .local_oob(local_oob), .ret_pc(ret_pc),
        .ret_pc_vld(ret_pc_vld), .depth(depth), .done(done), .trap(trap), .trap_code(trap_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv, rv;
        logic [7:0]  pn, ln;
        logic [15:0] pc;
        logic [8:0]  top;
        logic [7:0]  li;
        logic        e_cg, e_rg;
        logic [7:0]  e_al;
        logic [8:0]  e_fb, e_la;
        logic        e_oob;
        logic [15:0] e_rpc;
        logic        e_rpv;
        logic [4:0]  e_dp;
        logic        e_dn, e_tr;
        logic [1:0]  e_tc;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp, input int idx);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    endtask

    task automatic drive(input logic cv, input logic rv, input logic [7:0] pn, input logic [7:0] ln,
                         input logic [15:0] pc, input logic [8:0] top, input logic [7:0] li);
        call_vld = cv; ret_vld = rv; call_param_num = pn; call_local_num = ln;
        call_ret_pc = pc; top_pointer = top; local_idx = li;
    endtask

    // Caller is at posedge+1; inputs settle, outputs are sampled mid-cycle, then one edge passes.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input vec_t v, input int idx);
        chk("call_go",    call_go,    v.e_cg,  idx);
        chk("ret_go",     ret_go,     v.e_rg,  idx);
        chk("alloc_size", alloc_size, v.e_al,  idx);
        chk("frame_base", frame_base, v.e_fb,  idx);
        chk("l_addr",     l_addr,     v.e_la,  idx);
        chk("local_oob",  local_oob,  v.e_oob, idx);
        chk("ret_pc",     ret_pc,     v.e_rpc, idx);
        chk("ret_pc_vld", ret_pc_vld, v.e_rpv, idx);
        chk("depth",      depth,      v.e_dp,  idx);
        chk("done",       done,       v.e_dn,  idx);
        chk("trap",       trap,       v.e_tr,  idx);
        chk("trap_code",  trap_code,  v.e_tc,  idx);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        step();
    endtask

    function automatic vec_t mk(input logic cv, rv, input logic [7:0] pn, ln, input logic [15:0] pc,
                                input logic [8:0] top, input logic [7:0] li,
                                input logic cg, rg, input logic [7:0] al, input logic [8:0] fb, la,
                                input logic oob, input logic [15:0] rpc, input logic rpv,
                                input logic [4:0] dp, input logic dn, tr, input logic [1:0] tc);
        vec_t v;
        v.cv = cv; v.rv = rv; v.pn = pn; v.ln = ln; v.pc = pc; v.top = top; v.li = li;
        v.e_cg = cg; v.e_rg = rg; v.e_al = al; v.e_fb = fb; v.e_la = la; v.e_oob = oob;
        v.e_rpc = rpc; v.e_rpv = rpv; v.e_dp = dp; v.e_dn = dn; v.e_tr = tr; v.e_tc = tc;
        return v;
    endfunction

    initial begin
        //            cv rv pn ln pc     top li   cg rg al fb  la  oob rpc    rpv dp dn tr tc
        vecs[0]  = mk(0, 0, 0, 0, 16'h0,  0, 0,   0, 0, 0, 0,  0,  1,  16'h0,  0,  0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 2, 3, 16'h40, 5, 0,   1, 0, 3, 0,  0,  1,  16'h0,  0,  0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 16'h0,  5, 4,   0, 0, 0, 3,  7,  0,  16'h0,  0,  1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 16'h0,  5, 5,   0, 0, 0, 3,  8,  1,  16'h0,  0,  1, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 16'h0,  5, 0,   0, 1, 0, 3,  3,  0,  16'h0,  0,  1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 16'h0,  3, 0,   0, 0, 0, 0,  0,  1,  16'h40, 1,  0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 16'h0,  3, 0,   0, 0, 0, 0,  0,  1,  16'h40, 0,  0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 1, 0, 16'h11, 10, 0,  1, 0, 0, 0,  0,  1,  16'h40, 0,  0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 2, 1, 16'h22, 12, 0,  1, 0, 1, 9,  9,  0,  16'h40, 0,  1, 0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 0, 16'h0,  12, 0,  0, 1, 0, 10, 10, 0,  16'h40, 0,  2, 0, 0, 0);
        vecs[10] = mk(0, 1, 0, 0, 16'h0,  12, 0,  0, 1, 0, 9,  9,  0,  16'h22, 1,  1, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 16'h0,  12, 0,  0, 0, 0, 0,  0,  1,  16'h11, 1,  0, 0, 0, 0);
        vecs[12] = mk(1, 0, 6, 0, 16'h55, 4, 0,   0, 0, 0, 0,  0,  1,  16'h11, 0,  0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 16'h0,  4, 0,   0, 0, 0, 0,  0,  1,  16'h11, 0,  0, 0, 1, 2);
        vecs[14] = mk(0, 1, 0, 0, 16'h0,  4, 0,   0, 0, 0, 0,  0,  1,  16'h11, 0,  0, 0, 1, 2);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12 rst_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].cv, vecs[i].rv, vecs[i].pn, vecs[i].ln, vecs[i].pc, vecs[i].top, vecs[i].li);
            #2;
            check_all(vecs[i], i);
            $display("vec %0d: call=%0b ret=%0b -> call_go=%0b ret_go=%0b base=%0d depth=%0d trap=%0b",
                     i, call_vld, ret_vld, call_go, ret_go, frame_base, depth, trap);
            step();
        end

        // Frame overflow: fill all 16 slots, the 17th call traps.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 1, 16'(i), 9'(2 * i), 0);
            #2;
            chk("ovf_call_go", call_go, 1, i);
            step();
        end
        drive(1, 0, 0, 1, 16'h99, 9'd40, 0);
        #2;
        chk("ovf17_call_go", call_go, 0, 16);
        $display("overflow call: depth=%0d call_go=%0b", depth, call_go);
        step();
        drive(0, 1, 0, 0, 0, 0, 0);
        #2;
        chk("ovf_trap", trap, 1, 0);
        chk("ovf_code", trap_code, 1, 0);
        chk("ovf_depth", depth, 16, 0);
        chk("ovf_ret_ignored", ret_go, 0, 0);
        step();
        chk("ovf_depth_hold", depth, 16, 1);
        chk("ovf_rpv", ret_pc_vld, 0, 1);

        // Call and return together traps with code 11; later errors don't overwrite it.
        do_reset();
        drive(1, 1, 0, 0, 16'h7, 3, 0);
        #2;
        chk("both_call_go", call_go, 0, 0);
        chk("both_ret_go", ret_go, 0, 0);
        step();
        drive(1, 0, 9, 0, 0, 2, 0);
        #2;
        chk("both_trap", trap, 1, 0);
        chk("both_code", trap_code, 3, 0);
        step();
        chk("both_code_hold", trap_code, 3, 1);
        chk("both_depth", depth, 0, 1);
        $display("call+ret: trap=%0b code=%0d", trap, trap_code);

        // Return at the root frame completes the program.
        do_reset();
        drive(0, 1, 0, 0, 0, 4, 0);
        #2;
        chk("root_ret_go", ret_go, 0, 0);
        step();
        drive(1, 0, 1, 1, 16'h3, 4, 0);
        #2;
        chk("done_set", done, 1, 0);
        chk("done_no_trap", trap, 0, 0);
        chk("done_call_ignored", call_go, 0, 0);
        step();
        chk("done_depth", depth, 0, 1);
        chk("done_base", frame_base, 0, 1);
        $display("root return: done=%0b depth=%0d", done, depth);

        // Async reset during the ret_pc_vld pulse, with three frames still saved.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 2, 16'(16'h100 + i), 9'(4 + 3 * i), 0);
            step();
        end
        drive(0, 1, 0, 0, 0, 20, 0);
        step();
        drive(0, 0, 0, 0, 0, 20, 0);
        #1;
        chk("pre_rst_rpv", ret_pc_vld, 1, 0);
        chk("pre_rst_depth", depth, 3, 0);
        chk("pre_rst_pc", ret_pc, 16'h103, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_rpv", ret_pc_vld, 0, 0);
        chk("rst_pc", ret_pc, 0, 0);
        chk("rst_depth", depth, 0, 0);
        chk("rst_base", frame_base, 0, 0);
        chk("rst_oob", local_oob, 1, 0);
        chk("rst_done", done, 0, 0);
        chk("rst_trap", trap, 0, 0);
        $display("async reset: depth=%0d ret_pc_vld=%0b ret_pc=%0h", depth, ret_pc_vld, ret_pc);
        #3 rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
